// File: rtl/l_transform_sequencer_if.sv
// rtl/l_transform_sequencer_if.sv - valid/ready block interface of the L-transform sequencer
interface l_transform_sequencer_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/l_transform_sequencer.sv
// rtl/l_transform_sequencer.sv - Kuznyechik L = R^ROUNDS sequencer, MULS GF(2^8) multipliers per cycle
module l_transform_sequencer #(
   parameter int MULS   = 1,
   parameter int ROUNDS = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   l_transform_sequencer_if.slave bus
);

   localparam int RW = $clog2(ROUNDS + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t        state_q, state_d;
   logic [127:0]  work_q, work_d;
   logic [127:0]  out_data_q, out_data_d;
   logic [7:0]    acc_q, acc_d;
   logic [3:0]    j_q, j_d;
   logic [RW-1:0] r_q, r_d;
   logic          in_ready_q, in_ready_d;

   logic [7:0]    prod_x;
   logic [3:0]    idx;
   logic [7:0]    acc_next;
   logic [127:0]  step_work;

   // GF(2^8) multiply modulo x^8+x^7+x^6+x+1; x^8 folds back as 0xC3
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   // Fixed R-step coefficient for byte a_i
   function automatic logic [7:0] coef(input logic [3:0] i);
      case (i)
         4'd15:   coef = 8'h94;
         4'd14:   coef = 8'h20;
         4'd13:   coef = 8'h85;
         4'd12:   coef = 8'h10;
         4'd11:   coef = 8'hC2;
         4'd10:   coef = 8'hC0;
         4'd9:    coef = 8'h01;
         4'd8:    coef = 8'hFB;
         4'd7:    coef = 8'h01;
         4'd6:    coef = 8'hC0;
         4'd5:    coef = 8'hC2;
         4'd4:    coef = 8'h10;
         4'd3:    coef = 8'h85;
         4'd2:    coef = 8'h20;
         4'd1:    coef = 8'h94;
         default: coef = 8'h01;
      endcase
   endfunction

   // Fold this cycle's MULS bytes, walking from a15 downwards as j advances
   always_comb begin
      prod_x = 8'h00;
      idx    = 4'd0;
      for (int m = 0; m < MULS; m++) begin
         idx    = 4'd15 - j_q - 4'(m);
         prod_x = prod_x ^ gf_mul(coef(idx), work_q[{idx, 3'b000} +: 8]);
      end
   end

   // Next-state logic: accept in IDLE, fold and shift in RUN, hold result in DONE
   always_comb begin
      state_d    = state_q;
      work_d     = work_q;
      out_data_d = out_data_q;
      acc_d      = acc_q;
      j_d        = j_q;
      r_d        = r_q;
      acc_next   = acc_q ^ prod_x;
      step_work  = {acc_next, work_q[127:8]};

      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               work_d  = bus.in_data;
               acc_d   = 8'h00;
               j_d     = 4'd0;
               r_d     = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            acc_d = acc_next;
            j_d   = j_q + 4'(MULS);
            // j wrapping means all 16 bytes are folded: shift the new byte in
            if (j_d == 4'd0) begin
               work_d = step_work;
               acc_d  = 8'h00;
               r_d    = r_q + RW'(1);
               if (r_d == RW'(ROUNDS)) begin
                  out_data_d = step_work;
                  state_d    = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Registered so in_ready stays low while reset is held and rises after release
      in_ready_d = (state_d == ST_IDLE);
   end

   // State and datapath registers; reset discards any partial result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         work_q     <= '0;
         out_data_q <= '0;
         acc_q      <= 8'h00;
         j_q        <= 4'd0;
         r_q        <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         work_q     <= work_d;
         out_data_q <= out_data_d;
         acc_q      <= acc_d;
         j_q        <= j_d;
         r_q        <= r_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.busy      = (state_q == ST_RUN);
   assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_l_transform_sequencer.sv
// tb/tb_l_transform_sequencer.sv - randomized self-checking bench for l_transform_sequencer
module tb_l_transform_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [7:0] COEF [16] = '{8'h01, 8'h94, 8'h20, 8'h85, 8'h10, 8'hC2, 8'hC0, 8'h01,
                                        8'hFB, 8'h01, 8'hC0, 8'hC2, 8'h10, 8'h85, 8'h20, 8'h94};

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Carry-less product followed by long division by 0x1C3
   function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0000;
      for (int k = 0; k < 8; k++)
         if (b[k]) p = p ^ (16'(a) << k);
      for (int k = 14; k >= 8; k--)
         if (p[k]) p = p ^ (16'h01C3 << (k - 8));
      return p[7:0];
   endfunction

   function automatic logic [127:0] ref_l(input logic [127:0] blk, input int rounds);
      logic [7:0]   a [16];
      logic [7:0]   l;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) a[i] = blk[8*i +: 8];
      for (int r = 0; r < rounds; r++) begin
         l = 8'h00;
         for (int i = 0; i < 16; i++) l = l ^ ref_gmul(COEF[i], a[i]);
         for (int i = 0; i < 15; i++) a[i] = a[i+1];
         a[15] = l;
      end
      for (int i = 0; i < 16; i++) res[8*i +: 8] = a[i];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Single-R instance used for the chained bring-up vectors
   logic rst_n_r1;
   l_transform_sequencer_if r1_bus ();
   l_transform_sequencer #(.MULS(1), .ROUNDS(1)) u_dut_r1 (.clk(clk), .rst_n(rst_n_r1), .bus(r1_bus));

   task automatic r1_run(input logic [127:0] din, input logic [127:0] exp, input string tag);
      int n;
      r1_bus.in_data  = din;
      r1_bus.in_valid = 1'b1;
      @(negedge clk);
      r1_bus.in_valid = 1'b0;
      n = 0;
      while (!r1_bus.out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, 128'(n), 128'(16));
      check({tag, " data"}, r1_bus.out_data, exp);
      r1_bus.out_ready = 1'b1;
      @(negedge clk);
      r1_bus.out_ready = 1'b0;
   endtask

   // Full-L instances, one per legal MULS, each with its own reset and stimulus
   for (genvar g = 0; g < 5; g++) begin : g_m
      localparam int M      = 1 << g;
      localparam int LAT    = 256 / M;
      localparam int RST_AT = (LAT > 200) ? 100 : LAT / 2;
      localparam int NBLK   = 10;

      logic rst_n_g;
      logic fin = 1'b0;
      l_transform_sequencer_if bus ();
      l_transform_sequencer #(.MULS(M), .ROUNDS(16)) u_dut (.clk(clk), .rst_n(rst_n_g), .bus(bus));

      function automatic string tg(input string s);
         return $sformatf("m%0d %s", M, s);
      endfunction

      initial begin
         logic [127:0] held;
         logic [127:0] blk;
         logic [127:0] prev_data;
         logic [127:0] exp_q [$];
         logic         acc;
         logic         rdy;
         logic         prev_stall;
         int           n;
         int           n_out;
         int           guard;
         int           g2;

         rst_n_g      = 1'b0;
         bus.in_valid = 1'b0;
         bus.in_data  = '0;
         bus.out_ready = 1'b0;
         repeat (3) @(negedge clk);
         check(tg("rst in_ready"), 128'(bus.in_ready), 128'(0));
         check(tg("rst out_valid"), 128'(bus.out_valid), 128'(0));
         check(tg("rst busy"), 128'(bus.busy), 128'(0));
         check(tg("rst out_data"), bus.out_data, 128'(0));
         rst_n_g = 1'b1;
         @(negedge clk);
         check(tg("post-rst in_ready"), 128'(bus.in_ready), 128'(1));

         // Known-answer vector with latency measurement
         bus.in_data  = 128'h64a59400000000000000000000000000;
         bus.in_valid = 1'b1;
         @(negedge clk);
         bus.in_valid = 1'b0;
         check(tg("run busy"), 128'(bus.busy), 128'(1));
         check(tg("run in_ready"), 128'(bus.in_ready), 128'(0));
         n = 0;
         while (!bus.out_valid && n < LAT + 8) begin
            @(negedge clk);
            n++;
         end
         check(tg("kat latency"), 128'(n), 128'(LAT));
         check(tg("kat data"), bus.out_data, 128'hd456584dd0e3e84cc3166e4b7fa2890d);

         // Backpressure in DONE with a stray in_valid pulse
         held = bus.out_data;
         for (int c = 0; c < 20; c++) begin
            bus.in_valid = (c == 7);
            bus.in_data  = rand128();
            @(negedge clk);
            check(tg("bp out_valid"), 128'(bus.out_valid), 128'(1));
            check(tg("bp out_data"), bus.out_data, held);
            check(tg("bp in_ready"), 128'(bus.in_ready), 128'(0));
         end
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
         check(tg("release out_valid"), 128'(bus.out_valid), 128'(0));
         check(tg("release in_ready"), 128'(bus.in_ready), 128'(1));
         check(tg("release busy"), 128'(bus.busy), 128'(0));
         check(tg("release out_data"), bus.out_data, held);

         // Reset in the middle of RUN with in_valid held high
         bus.in_data  = rand128();
         bus.in_valid = 1'b1;
         @(negedge clk);
         repeat (RST_AT - 1) @(negedge clk);
         check(tg("pre-rst busy"), 128'(bus.busy), 128'(1));
         #1;
         rst_n_g = 1'b0;
         #1;
         check(tg("mid-rst in_ready"), 128'(bus.in_ready), 128'(0));
         check(tg("mid-rst out_valid"), 128'(bus.out_valid), 128'(0));
         check(tg("mid-rst busy"), 128'(bus.busy), 128'(0));
         check(tg("mid-rst out_data"), bus.out_data, 128'(0));
         @(negedge clk);
         @(negedge clk);
         bus.in_valid = 1'b0;
         rst_n_g      = 1'b1;
         @(negedge clk);
         blk          = rand128();
         bus.in_data  = blk;
         bus.in_valid = 1'b1;
         @(negedge clk);
         bus.in_valid = 1'b0;
         n = 0;
         while (!bus.out_valid && n < LAT + 8) begin
            @(negedge clk);
            n++;
         end
         check(tg("after-rst latency"), 128'(n), 128'(LAT));
         check(tg("after-rst data"), bus.out_data, ref_l(blk, 16));
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;

         // Back-to-back random blocks with random output stalls
         exp_q.delete();
         n_out = 0;
         fork
            begin : prod
               for (int b = 0; b < NBLK; b++) begin
                  repeat ($urandom_range(0, 3)) @(negedge clk);
                  blk          = rand128();
                  bus.in_data  = blk;
                  bus.in_valid = 1'b1;
                  guard = 0;
                  do begin
                     acc = bus.in_ready;
                     @(negedge clk);
                     guard++;
                  end while (!acc && guard < 2 * LAT + 200);
                  bus.in_valid = 1'b0;
                  check(tg("stream accept"), 128'(acc), 128'(1));
                  if (acc) exp_q.push_back(ref_l(blk, 16));
               end
            end
            begin : cons
               g2         = 0;
               prev_stall = 1'b0;
               prev_data  = '0;
               while (n_out < NBLK && g2 < NBLK * (LAT + 100)) begin
                  rdy           = 1'($urandom);
                  bus.out_ready = rdy;
                  if (bus.out_valid) begin
                     if (prev_stall) check(tg("stream stall hold"), bus.out_data, prev_data);
                     if (rdy) begin
                        check(tg("stream expected pending"), 128'(exp_q.size() > 0), 128'(1));
                        if (exp_q.size() > 0) check(tg("stream data"), bus.out_data, exp_q.pop_front());
                        n_out++;
                     end
                  end
                  prev_stall = bus.out_valid && !rdy;
                  prev_data  = bus.out_data;
                  @(negedge clk);
                  g2++;
               end
               bus.out_ready = 1'b0;
            end
         join
         check(tg("stream count"), 128'(n_out), 128'(NBLK));
         check(tg("stream leftovers"), 128'(exp_q.size()), 128'(0));
         fin = 1'b1;
      end
   end

   initial begin
      logic [127:0] blk;
      logic         all_fin;

      rst_n_r1         = 1'b0;
      r1_bus.in_valid  = 1'b0;
      r1_bus.in_data   = '0;
      r1_bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("r1 rst in_ready", 128'(r1_bus.in_ready), 128'(0));
      check("r1 rst out_data", r1_bus.out_data, 128'(0));
      rst_n_r1 = 1'b1;
      @(negedge clk);
      check("r1 post-rst in_ready", 128'(r1_bus.in_ready), 128'(1));

      r1_run(128'h00000000000000000000000000000100, 128'h94000000000000000000000000000001, "r1 v0");
      r1_run(128'h94000000000000000000000000000001, 128'ha5940000000000000000000000000000, "r1 v1");
      r1_run(128'ha5940000000000000000000000000000, 128'h64a59400000000000000000000000000, "r1 v2");
      r1_run(128'h64a59400000000000000000000000000, 128'h0d64a594000000000000000000000000, "r1 v3");
      r1_run(128'h0, 128'h0, "r1 zero");
      for (int k = 0; k < 6; k++) begin
         blk = rand128();
         r1_run(blk, ref_l(blk, 1), "r1 rand");
      end

      all_fin = 1'b0;
      for (int c = 0; c < 20000 && !all_fin; c++) begin
         @(negedge clk);
         all_fin = g_m[0].fin && g_m[1].fin && g_m[2].fin && g_m[3].fin && g_m[4].fin;
      end
      check("all streams finished", 128'(all_fin), 128'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
